// File: rtl/jacobi_pkg.sv
// ---------------------------------------------------------------------------
// jacobi_pkg
// Shared definitions for the Jacobi sweep scheduler:
//   jacobi_state_e : controller state encoding
//   npairs(n)      : number of off-diagonal pairs visited per sweep
// ---------------------------------------------------------------------------
package jacobi_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ANG,
    S_W_ANG,
    S_ROTL,
    S_W_ROTL,
    S_ROTR,
    S_W_ROTR,
    S_NEXT,
    S_FIN
  } jacobi_state_e;

  function automatic int unsigned npairs(input int unsigned n);
    return (n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/jacobi_pair_gen.sv
// ---------------------------------------------------------------------------
// jacobi_pair_gen
// Cyclic-by-row (p,q) pair counter over the strict upper triangle of an
// N x N matrix: (0,1)(0,2)..(0,N-1)(1,2)..(N-2,N-1).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (to (0,1))
//   clr        : return to the first pair (0,1)
//   adv        : step to the next pair (clr has priority)
//   p, q       : current row / column index (registered)
//   last       : current pair is (N-2,N-1)
// ---------------------------------------------------------------------------
module jacobi_pair_gen
  import jacobi_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  output logic [$clog2(N)-1:0] p,
  output logic [$clog2(N)-1:0] q,
  output logic                 last
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_Q = PW'(N - 1);
  localparam logic [PW-1:0] LAST_P = PW'(N - 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      q <= PW'(1);
    end else if (clr) begin
      p <= '0;
      q <= PW'(1);
    end else if (adv) begin
      if (q != LAST_Q) begin
        q <= q + PW'(1);
      end else begin
        // wrap to the next row, starting just right of the diagonal
        p <= p + PW'(1);
        q <= p + PW'(2);
      end
    end
  end

  assign last = (p == LAST_P) && (q == LAST_Q);

endmodule

// File: rtl/jacobi_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// jacobi_sweep_ctrl
// Cyclic-by-row Jacobi sweep scheduler. For every off-diagonal pair (p,q) it
// runs angle unit -> left rotation -> right rotation (rotations skipped when
// the angle unit reports a negligible a_pq), and repeats whole sweeps until a
// sweep performs no rotation or MAX_SWEEPS sweeps have completed.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : begin decomposition (accepted only when idle)
//   abort                  : return to idle from any busy state, no done
//   busy                   : high in every state except idle
//   done                   : one-cycle pulse on normal completion
//   converged              : last run ended on a rotation-free sweep
//   sweep_cnt              : completed sweeps of the current/last run
//   p_idx, q_idx           : current pair indices
//   ang_start/ang_done/ang_skip   : angle unit handshake
//   rotl_start/rotl_done          : left rotation unit handshake
//   rotr_start/rotr_done          : right rotation unit handshake
// All outputs are registered.
// ---------------------------------------------------------------------------
module jacobi_sweep_ctrl
  import jacobi_pkg::*;
#(
  parameter int N          = 4,
  parameter int MAX_SWEEPS = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [$clog2(MAX_SWEEPS+1)-1:0] sweep_cnt,
  output logic [$clog2(N)-1:0]            p_idx,
  output logic [$clog2(N)-1:0]            q_idx,
  output logic                            ang_start,
  input  logic                            ang_done,
  input  logic                            ang_skip,
  output logic                            rotl_start,
  input  logic                            rotl_done,
  output logic                            rotr_start,
  input  logic                            rotr_done
);

  localparam int SW = $clog2(MAX_SWEEPS + 1);
  localparam logic [SW-1:0] SWEEP_LIMIT = SW'(MAX_SWEEPS);

  jacobi_state_e state, state_nxt;
  logic          rot_flag, rot_flag_nxt;
  logic          conv_nxt;
  logic [SW-1:0] sweep_nxt;
  logic          pair_clr, pair_adv, pair_last;

  jacobi_pair_gen #(.N(N)) u_pair_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pair_clr),
    .adv   (pair_adv),
    .p     (p_idx),
    .q     (q_idx),
    .last  (pair_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rot_flag_nxt = rot_flag;
    conv_nxt     = converged;
    sweep_nxt    = sweep_cnt;
    pair_clr     = 1'b0;
    pair_adv     = 1'b0;
    // abort outranks any unit completion arriving in the same cycle
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
      conv_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt    = S_ANG;
            pair_clr     = 1'b1;
            sweep_nxt    = '0;
            rot_flag_nxt = 1'b0;
            conv_nxt     = 1'b0;
          end
        end
        S_ANG:  state_nxt = S_W_ANG;
        S_W_ANG: begin
          if (ang_done) begin
            if (ang_skip) begin
              state_nxt = S_NEXT;
            end else begin
              state_nxt    = S_ROTL;
              rot_flag_nxt = 1'b1;
            end
          end
        end
        S_ROTL:   state_nxt = S_W_ROTL;
        S_W_ROTL: if (rotl_done) state_nxt = S_ROTR;
        S_ROTR:   state_nxt = S_W_ROTR;
        S_W_ROTR: if (rotr_done) state_nxt = S_NEXT;
        S_NEXT: begin
          if (!pair_last) begin
            pair_adv  = 1'b1;
            state_nxt = S_ANG;
          end else begin
            sweep_nxt = sweep_cnt + SW'(1);
            if (!rot_flag) begin
              conv_nxt  = 1'b1;
              state_nxt = S_FIN;
            end else if (sweep_nxt == SWEEP_LIMIT) begin
              state_nxt = S_FIN;
            end else begin
              pair_clr     = 1'b1;
              rot_flag_nxt = 1'b0;
              state_nxt    = S_ANG;
            end
          end
        end
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // is high exactly during the cycle the controller sits in its issue state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      sweep_cnt  <= '0;
      rot_flag   <= 1'b0;
      ang_start  <= 1'b0;
      rotl_start <= 1'b0;
      rotr_start <= 1'b0;
    end else begin
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_FIN);
      converged  <= conv_nxt;
      sweep_cnt  <= sweep_nxt;
      rot_flag   <= rot_flag_nxt;
      ang_start  <= (state_nxt == S_ANG);
      rotl_start <= (state_nxt == S_ROTL);
      rotr_start <= (state_nxt == S_ROTR);
    end
  end

endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jacobi_sweep_ctrl
// Scoreboard bench: stimulus pushes the expected strobe/done events into a
// queue, monitors pop and compare whenever a DUT strobe appears. Two DUTs:
// N=4/MAX_SWEEPS=2 for most scenarios, N=2/MAX_SWEEPS=1 for the minimal case.
// Event code = kind*100 + a*10 + b ; kind 0/1/2 = ang/rotl/rotr start with
// (a,b)=(p,q), kind 3 = done with (a,b)=(converged,sweep_cnt).
// ---------------------------------------------------------------------------
module tb_jacobi_sweep_ctrl;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, ang_done, ang_skip, rotl_done, rotr_done;
  logic       busy, done, converged, ang_start, rotl_start, rotr_start;
  logic [1:0] sweep_cnt, p_idx, q_idx;

  logic       start2, abort2, ang_done2, ang_skip2, rotl_done2, rotr_done2;
  logic       busy2, done2, converged2, ang_start2, rotl_start2, rotr_start2;
  logic [0:0] sweep_cnt2, p_idx2, q_idx2;

  jacobi_sweep_ctrl #(.N(4), .MAX_SWEEPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .converged(converged), .sweep_cnt(sweep_cnt),
    .p_idx(p_idx), .q_idx(q_idx),
    .ang_start(ang_start), .ang_done(ang_done), .ang_skip(ang_skip),
    .rotl_start(rotl_start), .rotl_done(rotl_done),
    .rotr_start(rotr_start), .rotr_done(rotr_done)
  );

  jacobi_sweep_ctrl #(.N(2), .MAX_SWEEPS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .converged(converged2), .sweep_cnt(sweep_cnt2),
    .p_idx(p_idx2), .q_idx(q_idx2),
    .ang_start(ang_start2), .ang_done(ang_done2), .ang_skip(ang_skip2),
    .rotl_start(rotl_start2), .rotl_done(rotl_done2),
    .rotr_start(rotr_start2), .rotr_done(rotr_done2)
  );

  int errors = 0;
  int checks = 0;
  int q4[$];
  int q2[$];

  function automatic int enc(input int k, input int a, input int b);
    return k * 100 + a * 10 + b;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic pop4(input string nm, input int got);
    int e;
    if (q4.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event got=%0d exp=none", nm, got);
    end else begin
      e = q4.pop_front();
      check(nm, got, e);
    end
  endtask

  task automatic pop2(input string nm, input int got);
    int e;
    if (q2.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event got=%0d exp=none", nm, got);
    end else begin
      e = q2.pop_front();
      check(nm, got, e);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (ang_start  === 1'b1) pop4("ang_start4",  enc(0, int'(p_idx), int'(q_idx)));
    if (rotl_start === 1'b1) pop4("rotl_start4", enc(1, int'(p_idx), int'(q_idx)));
    if (rotr_start === 1'b1) pop4("rotr_start4", enc(2, int'(p_idx), int'(q_idx)));
    if (done       === 1'b1) pop4("done4",       enc(3, int'(converged), int'(sweep_cnt)));
  end

  always @(negedge clk) begin
    if (ang_start2  === 1'b1) pop2("ang_start2",  enc(0, int'(p_idx2), int'(q_idx2)));
    if (rotl_start2 === 1'b1) pop2("rotl_start2", enc(1, int'(p_idx2), int'(q_idx2)));
    if (rotr_start2 === 1'b1) pop2("rotr_start2", enc(2, int'(p_idx2), int'(q_idx2)));
    if (done2       === 1'b1) pop2("done2",       enc(3, int'(converged2), int'(sweep_cnt2)));
  end

  // unit models for the N=4 DUT
  int ca = 0, cl = 0, cr = 0, ang_cnt = 0;
  int skip_from = -1;
  int stray_at = -1;
  bit abort_armed = 1'b0;
  bit cur_skip = 1'b0;
  bit stray_next = 1'b0;

  initial begin
    ang_done = 0; ang_skip = 0; rotl_done = 0; rotr_done = 0; abort = 0;
    forever begin
      @(negedge clk);
      ang_done = 0; ang_skip = 0; rotl_done = 0; rotr_done = 0; abort = 0;
      if (rst_n !== 1'b1) begin
        ca = 0; cl = 0; cr = 0; stray_next = 0; ang_cnt = 0;
      end else begin
        if (busy !== 1'b1) ang_cnt = 0;
        if (stray_next) begin
          rotr_done  = 1;
          stray_next = 0;
        end
        if (ca > 0) begin
          ca--;
          if (ca == 0) begin ang_done = 1; ang_skip = cur_skip; end
        end
        if (cl > 0) begin
          cl--;
          if (cl == 0) begin
            rotl_done = 1;
            if (abort_armed && p_idx == 2'd1 && q_idx == 2'd2) abort = 1;
          end
        end
        if (cr > 0) begin
          cr--;
          if (cr == 0) rotr_done = 1;
        end
        if (ang_start === 1'b1) begin
          ca       = LAT;
          cur_skip = (skip_from >= 0) && (ang_cnt >= skip_from);
          if (ang_cnt == stray_at) stray_next = 1;
          ang_cnt++;
        end
        if (rotl_start === 1'b1) cl = LAT;
        if (rotr_start === 1'b1) cr = LAT;
      end
    end
  end

  // unit models for the N=2 DUT (1-cycle response, never skip)
  int ca2 = 0, cl2 = 0, cr2 = 0;
  initial begin
    ang_done2 = 0; ang_skip2 = 0; rotl_done2 = 0; rotr_done2 = 0; abort2 = 0;
    forever begin
      @(negedge clk);
      ang_done2 = 0; rotl_done2 = 0; rotr_done2 = 0;
      if (ca2 > 0) begin ca2--; if (ca2 == 0) ang_done2  = 1; end
      if (cl2 > 0) begin cl2--; if (cl2 == 0) rotl_done2 = 1; end
      if (cr2 > 0) begin cr2--; if (cr2 == 0) rotr_done2 = 1; end
      if (ang_start2  === 1'b1) ca2 = 1;
      if (rotl_start2 === 1'b1) cl2 = 1;
      if (rotr_start2 === 1'b1) cr2 = 1;
    end
  end

  task automatic push_pair4(input int p, input int q, input bit rot);
    q4.push_back(enc(0, p, q));
    if (rot) begin
      q4.push_back(enc(1, p, q));
      q4.push_back(enc(2, p, q));
    end
  endtask

  task automatic push_sweep4(input bit rot);
    for (int p = 0; p < 3; p++)
      for (int q = p + 1; q < 4; q++)
        push_pair4(p, q, rot);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       int'(busy),       0);
    check({tag, "_done"},       int'(done),       0);
    check({tag, "_converged"},  int'(converged),  0);
    check({tag, "_ang_start"},  int'(ang_start),  0);
    check({tag, "_rotl_start"}, int'(rotl_start), 0);
    check({tag, "_rotr_start"}, int'(rotr_start), 0);
    check({tag, "_sweep_cnt"},  int'(sweep_cnt),  0);
    check({tag, "_p_idx"},      int'(p_idx),      0);
    check({tag, "_q_idx"},      int'(q_idx),      1);
  endtask

  task automatic do_start4();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    #1;
    check("busy_after_start",      int'(busy),      1);
    check("ang_start_after_start", int'(ang_start), 1);
    check("sweep_cnt_cleared",     int'(sweep_cnt), 0);
  endtask

  task automatic wait_done4(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    if (!seen) check({nm, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    bit hit;
    rst_n = 0; start = 0; start2 = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_busy2", int'(busy2), 0);
    @(negedge clk);
    rst_n = 1;

    // 1: every pair rotates, sweep limit reached
    push_sweep4(1); push_sweep4(1);
    q4.push_back(enc(3, 0, 2));
    do_start4();
    wait_done4("t1");
    @(negedge clk);
    #1;
    check("t1_busy_after_done", int'(busy), 0);
    check("t1_queue_empty", q4.size(), 0);

    // 2: second sweep fully skipped -> converged
    skip_from = 6;
    push_sweep4(1); push_sweep4(0);
    q4.push_back(enc(3, 1, 2));
    do_start4();
    wait_done4("t2");
    repeat (3) @(negedge clk);
    #1;
    check("t2_converged_held", int'(converged), 1);
    check("t2_sweep_cnt_held", int'(sweep_cnt), 2);
    check("t2_busy", int'(busy), 0);
    check("t2_queue_empty", q4.size(), 0);
    skip_from = -1;

    // 3: abort in W_ROTL of (1,2) together with rotl_done
    abort_armed = 1;
    push_pair4(0, 1, 1); push_pair4(0, 2, 1); push_pair4(0, 3, 1);
    q4.push_back(enc(0, 1, 2));
    q4.push_back(enc(1, 1, 2));
    do_start4();
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (abort === 1'b1) hit = 1;
    end
    if (!hit) check("t3_abort_timeout", 0, 1);
    @(negedge clk);
    #1;
    check("t3_busy_after_abort", int'(busy), 0);
    check("t3_no_rotr_start", int'(rotr_start), 0);
    check("t3_no_done", int'(done), 0);
    check("t3_converged", int'(converged), 0);
    abort_armed = 0;
    repeat (5) @(negedge clk);
    #1;
    check("t3_sweep_cnt_kept", int'(sweep_cnt), 0);
    check("t3_queue_empty", q4.size(), 0);

    // 4: start while busy and stray rotr_done during W_ANG of (0,3)
    stray_at = 2;
    push_sweep4(1); push_sweep4(1);
    q4.push_back(enc(3, 0, 2));
    do_start4();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (ang_start === 1'b1 && p_idx == 2'd0 && q_idx == 2'd3) hit = 1;
    end
    if (!hit) check("t4_pair03_timeout", 0, 1);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done4("t4");
    check("t4_queue_empty", q4.size(), 0);
    stray_at = -1;

    // 5: reset in sweep 2, then restart from (0,1)
    push_sweep4(1);
    push_pair4(0, 1, 1); push_pair4(0, 2, 1); push_pair4(0, 3, 1); push_pair4(1, 2, 1);
    q4.push_back(enc(0, 1, 3));
    do_start4();
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (ang_start === 1'b1 && sweep_cnt == 2'd1 && p_idx == 2'd1 && q_idx == 2'd3) hit = 1;
    end
    if (!hit) check("t5_reach_timeout", 0, 1);
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("t5_queue_empty_after_reset", q4.size(), 0);
    skip_from = 0;
    push_sweep4(0);
    q4.push_back(enc(3, 1, 1));
    do_start4();
    wait_done4("t5");
    check("t5_queue_empty", q4.size(), 0);
    skip_from = -1;

    // 6: N=2, MAX_SWEEPS=1, single pair with rotation
    q2.push_back(enc(0, 0, 1));
    q2.push_back(enc(1, 0, 1));
    q2.push_back(enc(2, 0, 1));
    q2.push_back(enc(3, 0, 1));
    @(negedge clk);
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    #1;
    check("t6_busy2_after_start", int'(busy2), 1);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (done2 === 1'b1) hit = 1;
    end
    if (!hit) check("t6_done2_timeout", 0, 1);
    @(negedge clk);
    #1;
    check("t6_busy2_after_done", int'(busy2), 0);
    check("t6_queue_empty", q2.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
